// File: rtl/display_scan_ctrl.sv
// Digit-scan controller for a 4-digit 7-segment display: one-hot digit select,
// active-low anodes with inter-digit dead-time, frame-latched value and leading-zero blanking.
module display_scan_ctrl #(
   parameter int unsigned PRESCALE     = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic [15:0] nval,
   output logic [3:0]  sel,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int unsigned MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned GAP_END = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_END);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       sel_q, sel_d;
   logic [3:0]       an_q, an_d;
   logic [15:0]      nval_q, nval_d;
   logic             tick_q, tick_d;
   logic             rotate;
   logic [3:0]       blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= 4'b0001;
         an_q    <= 4'b1111;
         nval_q  <= 16'h0000;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         nval_q  <= nval_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      nval_d  = nval_q;
      tick_d  = 1'b0;
      rotate  = 1'b0;
      blank   = 4'b0000;
      an_d    = 4'b1111;

      if (!en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         sel_d   = 4'b0001;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ON;
               cnt_d   = '0;
               sel_d   = 4'b0001;
               nval_d  = value;
            end
            S_ON: begin
               if (cnt_q == ON_LAST) begin
                  cnt_d = '0;
                  if (BLANK_CYCLES == 0) begin
                     rotate = 1'b1;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = S_ON;
                  cnt_d   = '0;
                  rotate  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               sel_d   = 4'b0001;
            end
         endcase
      end

      // Leaving the leftmost digit closes the frame: latch a fresh value.
      if (rotate) begin
         sel_d = {sel_q[2:0], sel_q[3]};
         if (sel_q[3]) begin
            nval_d = value;
            tick_d = 1'b1;
         end
      end

      blank[3] = (nval_d[15:12] == 4'h0);
      blank[2] = blank[3] && (nval_d[11:8] == 4'h0);
      blank[1] = blank[2] && (nval_d[7:4] == 4'h0);
      blank[0] = 1'b0;

      if ((state_d == S_ON) && !(blank_lz && ((sel_d & blank) != 4'b0000))) begin
         an_d = ~sel_d;
      end
   end

   assign nval       = nval_q;
   assign sel        = sel_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule
